// File: rtl/buffer_pkg.sv
// buffer_pkg: shared helpers for the circular multi-word register-file buffer.
package buffer_pkg;

    function automatic bit is_pow2(input int n);
        return n > 0 && (n & (n - 1)) == 0;
    endfunction

endpackage

// File: rtl/buffer_read_mux.sv
// buffer_read_mux: SIZE:1 word selector used once per read-window word.
module buffer_read_mux #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int BIT   = $clog2(SIZE)
) (
    input  logic [WIDTH-1:0] mem [SIZE],
    input  logic [BIT-1:0]   sel,
    output logic [WIDTH-1:0] word
);

    assign word = mem[sel];

endmodule

// File: rtl/buffer.sv
// buffer: circular register file, K-word synchronous write window and J-word combinational read window.
module buffer
    import buffer_pkg::*;
#(
    parameter int SIZE  = 16,
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int J     = 4,
    parameter int BIT   = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic [BIT-1:0]     write_add,
    input  logic [BIT-1:0]     read_add,
    input  logic [WIDTH*K-1:0] par_in,
    output logic [WIDTH*J-1:0] par_out
);

    if (!is_pow2(SIZE)) begin : g_size_chk
        $error("buffer: SIZE must be a power of two");
    end
    if (K > SIZE || J > SIZE) begin : g_win_chk
        $error("buffer: K and J must not exceed SIZE");
    end

    logic [WIDTH-1:0] mem [SIZE];
    logic [BIT-1:0]   wa  [K];

    // BIT-wide sums truncate, so windows wrap past SIZE-1 back to 0
    for (genvar i = 0; i < K; i++) begin : g_wa
        assign wa[i] = write_add + BIT'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            for (int e = 0; e < SIZE; e++) mem[e] <= '0;
        else if (ld)
            for (int i = 0; i < K; i++) mem[wa[i]] <= par_in[i*WIDTH +: WIDTH];
    end

    for (genvar j = 0; j < J; j++) begin : g_rd
        buffer_read_mux #(.SIZE(SIZE), .WIDTH(WIDTH), .BIT(BIT)) u_mux (
            .mem  (mem),
            .sel  (read_add + BIT'(j)),
            .word (par_out[j*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_buffer.sv
// tb_buffer: directed checks of reset, windowed writes, wrap-around and write/read ordering.
module tb_buffer;

    logic        clk = 0;
    logic        rst;
    logic        ld;
    logic [3:0]  write_add;
    logic [3:0]  read_add;
    logic [31:0] par_in;
    logic [31:0] par_out;
    int          checks = 0;
    int          errors = 0;

    buffer dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .write_add (write_add),
        .read_add  (read_add),
        .par_in    (par_in),
        .par_out   (par_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        read_add = a;
        #1;
        check(tag, par_out, exp);
    endtask

    initial begin
        rst = 0; ld = 0; write_add = 0; read_add = 0; par_in = 0;
        tick();
        tick();
        rst = 1;
        for (int a = 0; a < 16; a++) rd($sformatf("reset_rd%0d", a), 4'(a), 32'h0);

        write_add = 0; par_in = 32'hD4C3B2A1; ld = 1;
        tick();
        ld = 0;
        rd("basic_rd0", 0, 32'hD4C3B2A1);
        rd("basic_rd1", 1, 32'h00D4C3B2);

        write_add = 1; par_in = 32'hD4C3B2A2; ld = 1;
        tick();
        ld = 0;
        rd("ovl_rd0", 0, 32'hC3B2A2A1);
        rd("ovl_rd1", 1, 32'hD4C3B2A2);

        write_add = 14; par_in = 32'h44332211; ld = 1;
        tick();
        ld = 0;
        rd("wrap_rd14", 14, 32'h44332211);
        rd("wrap_rd15", 15, 32'hB2443322);
        rd("wrap_rd0", 0, 32'hC3B24433);

        write_add = 0; par_in = 32'h12345678;
        tick();
        rd("hold_rd0", 0, 32'hC3B24433);

        rd("sim_other_pre", 1, 32'hD4C3B244);
        write_add = 5; par_in = 32'hFFEEDDCC; ld = 1;
        rd("sim_pre", 5, 32'h00000000);
        tick();
        ld = 0;
        check("sim_post", par_out, 32'hFFEEDDCC);
        rd("sim_other_post", 1, 32'hD4C3B244);
        rd("sim_overlap", 3, 32'hDDCCD4C3);

        write_add = 6; par_in = 32'h44332211; ld = 1; rst = 0;
        tick();
        rst = 1; ld = 0;
        for (int a = 0; a < 16; a++) rd($sformatf("rstld_rd%0d", a), 4'(a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
